// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
//   alarm_state_t : ring/snooze FSM state, encoding visible on the state port
//   BCD_W         : width of one packed-BCD time field
//   BCD_ZERO      : minute value that marks the top of the hour
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int BCD_W = 8;
  localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/tick_counter.sv
// Small event counter with a terminal count.
//   clk, reset : clock and synchronous active-high reset
//   clear      : return the count to zero (wins over enable)
//   enable     : count one event this cycle
//   done       : the current event is the (TERMINAL+1)-th since the last clear
module tick_counter #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 59
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign done = enable && (cnt_q == TERM);

  // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = done ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop sequencer with an hourly chime.
//   clk, reset          : clock and synchronous active-high reset
//   sec_tick            : one-cycle pulse per second
//   hour, minute        : running time, packed BCD
//   arm                 : alarm enable level; low forces IDLE
//   set_en, set_hour,
//   set_minute          : load a new alarm time
//   snooze, stop        : one-cycle button pulses
//   alert               : registered buzzer drive, high while RINGING
//   chime               : registered top-of-hour chime
//   alarm_hour/minute   : stored alarm time
//   state, snooze_left  : FSM state and remaining snoozes, for display
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int CHIME_SEC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sec_tick,
  input  logic [BCD_W-1:0] hour,
  input  logic [BCD_W-1:0] minute,
  input  logic             arm,
  input  logic             set_en,
  input  logic [BCD_W-1:0] set_hour,
  input  logic [BCD_W-1:0] set_minute,
  input  logic             snooze,
  input  logic             stop,
  output logic             alert,
  output logic             chime,
  output logic [BCD_W-1:0] alarm_hour,
  output logic [BCD_W-1:0] alarm_minute,
  output logic [1:0]       state,
  output logic [1:0]       snooze_left
);

  alarm_state_t     state_q, state_d;
  logic [1:0]       snooze_left_q, snooze_left_d;
  logic             alert_q, alert_d;
  logic             chime_q, chime_d;
  logic [BCD_W-1:0] alarm_hour_q, alarm_hour_d;
  logic [BCD_W-1:0] alarm_minute_q, alarm_minute_d;
  logic [BCD_W-1:0] minute_q;

  logic min_evt, match, chime_start;
  logic sec_clr, sec_en, sec_done;
  logic min_clr, min_en, min_done;
  logic chime_clr, chime_en, chime_done;

  // Matching only on a minute change keeps a stopped alarm from re-ringing
  // for the rest of the matching minute.
  assign min_evt     = (minute != minute_q);
  assign match       = min_evt && arm && (hour == alarm_hour_q) && (minute == alarm_minute_q);
  assign chime_start = min_evt && (minute == BCD_ZERO);

  assign alarm_hour_d   = set_en ? set_hour   : alarm_hour_q;
  assign alarm_minute_d = set_en ? set_minute : alarm_minute_q;

  // Counters only advance in their own state, so a tick coincident with ring
  // entry (state_q still IDLE/SNOOZE) is not counted.
  assign sec_en   = (state_q == RINGING) && sec_tick;
  assign min_en   = (state_q == SNOOZE) && min_evt;
  assign chime_en = chime_q && sec_tick;

  tick_counter #(.WIDTH(6), .TERMINAL(RING_SEC - 1)) u_sec_cnt (
    .clk(clk), .reset(reset), .clear(sec_clr), .enable(sec_en), .done(sec_done)
  );

  tick_counter #(.WIDTH(4), .TERMINAL(SNOOZE_MIN - 1)) u_min_cnt (
    .clk(clk), .reset(reset), .clear(min_clr), .enable(min_en), .done(min_done)
  );

  tick_counter #(.WIDTH(3), .TERMINAL(CHIME_SEC - 1)) u_chime_cnt (
    .clk(clk), .reset(reset), .clear(chime_clr), .enable(chime_en), .done(chime_done)
  );

  // Priority within a cycle: !arm > stop > snooze > timeout/re-ring > match.
  always_comb begin
    state_d       = state_q;
    snooze_left_d = snooze_left_q;
    sec_clr       = 1'b0;
    min_clr       = 1'b0;
    if (!arm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d       = RINGING;
            sec_clr       = 1'b1;
            snooze_left_d = 2'(MAX_SNOOZE);
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            if (snooze_left_q != 2'd0) begin
              state_d       = SNOOZE;
              min_clr       = 1'b1;
              snooze_left_d = snooze_left_q - 2'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (sec_done) begin
            state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (min_done) begin
            state_d = RINGING;
            sec_clr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Suppression looks at the next state so a chime starting on the same
  // minute event that triggers the alarm never reaches the output.
  always_comb begin
    chime_d   = chime_q;
    chime_clr = 1'b0;
    if (state_d == RINGING) begin
      chime_d   = 1'b0;
      chime_clr = 1'b1;
    end else if (chime_start) begin
      chime_d   = 1'b1;
      chime_clr = 1'b1;
    end else if (chime_done) begin
      chime_d = 1'b0;
    end
  end

  assign alert_d = (state_d == RINGING);

  always_ff @(posedge clk) begin
    // minute_q follows minute in reset too, so no event fires right after release.
    minute_q <= minute;
    if (reset) begin
      state_q        <= IDLE;
      snooze_left_q  <= 2'd0;
      alert_q        <= 1'b0;
      chime_q        <= 1'b0;
      alarm_hour_q   <= BCD_ZERO;
      alarm_minute_q <= BCD_ZERO;
    end else begin
      state_q        <= state_d;
      snooze_left_q  <= snooze_left_d;
      alert_q        <= alert_d;
      chime_q        <= chime_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
    end
  end

  assign alert        = alert_q;
  assign chime        = chime_q;
  assign alarm_hour   = alarm_hour_q;
  assign alarm_minute = alarm_minute_q;
  assign state        = state_q;
  assign snooze_left  = snooze_left_q;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequencing controller for the alarm clock's alarm/ring path. It holds the programmed alarm time and detects minute roll-overs of the running clock. It runs the ring / snooze / stop state machine and produces the registered buzzer drive `alert` plus a separate top-of-hour `chime`. It sits between the clock counter (hour/minute, 1 Hz tick) and the buzzer/LED output stage, and replaces the free-running compare with a controlled, retrigger-safe sequence.

## Interface
Parameters:
- `RING_SEC`, default 60: seconds `alert` stays high before auto-stop (1..63).
- `SNOOZE_MIN`, default 5: minute roll-overs spent in SNOOZE before re-ring (1..15).
- `MAX_SNOOZE`, default 3: snoozes honoured per alarm event; further snooze presses act as stop.
- `CHIME_SEC`, default 2: seconds `chime` stays high at minute 00 (1..7).

Ports (clock and reset first):
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `sec_tick` in 1: one-cycle pulse, once per second.
- `hour` in 8: current hour, packed BCD 00–23.
- `minute` in 8: current minute, packed BCD 00–59.
- `arm` in 1: alarm enable level.
- `set_en` in 1: load `set_hour`/`set_minute` into the alarm registers.
- `set_hour` in 8: alarm hour, BCD.
- `set_minute` in 8: alarm minute, BCD.
- `snooze` in 1: one-cycle pulse (debounced upstream).
- `stop` in 1: one-cycle pulse (debounced upstream).
- `alert` out 1: buzzer drive, registered.
- `chime` out 1: hourly chime, registered.
- `alarm_hour` out 8: stored alarm hour.
- `alarm_minute` out 8: stored alarm minute.
- `state` out 2: FSM state, for display.
- `snooze_left` out 2: remaining snoozes.

## Operation
- Minute event (`min_evt`):
  - `min_evt = (minute != minute_q)`.
  - `minute_q` updates every cycle.
  - During reset `minute_q` loads the current `minute`, so no event fires in the first cycle after reset.
- Alarm match: `min_evt && arm && hour == alarm_hour && minute == alarm_minute`. Matching only on the event means a stopped alarm cannot retrigger within the same minute.
- FSM states (encoding): IDLE=0, RINGING=1, SNOOZE=2.
  - IDLE → RINGING on match. `sec_cnt` := 0. `snooze_left` := MAX_SNOOZE.
  - RINGING, `sec_tick`: increment `sec_cnt`. When `sec_cnt == RING_SEC-1` on a tick → IDLE.
  - RINGING, `snooze` with `snooze_left != 0` → SNOOZE. `min_cnt` := 0. `snooze_left` decrements.
  - RINGING, `snooze` with `snooze_left == 0` → IDLE.
  - RINGING, `stop` → IDLE.
  - SNOOZE, each `min_evt`: increment `min_cnt`. When `min_cnt == SNOOZE_MIN-1` on an event → RINGING, `sec_cnt` := 0.
  - SNOOZE, `stop` → IDLE.
  - Any state, `arm == 0` → IDLE (counters are don't-care).
  - Priority, same cycle: reset > !arm > stop > snooze > timeout/re-ring > match.
- `alert` = 1 exactly while in RINGING.
- Chime:
  - On `min_evt && minute == 8'h00`, `chime` goes high for CHIME_SEC `sec_tick`s via its own `chime_cnt`.
  - The chime is independent of `arm`.
  - It is suppressed (forced 0, counter cleared) while RINGING.
- Alarm registers:
  - `set_en` loads both registers the next cycle, in any state; the FSM is unaffected.
  - A new time takes effect on the next `min_evt`.
- Reset values:
  - `alert` = 0, `chime` = 0, `state` = IDLE.
  - `alarm_hour` = 8'h00, `alarm_minute` = 8'h00.
  - `snooze_left` = 0, all counters 0.
- Comparisons are on raw 8-bit BCD; invalid BCD input never matches a valid set time and is not checked.

## Timing
- A match seen in cycle N gives `state`=RINGING and `alert`=1 in N+1.
- `stop`/`snooze`/`!arm` in cycle N gives `alert`=0 in N+1.
- Auto-stop: `alert` falls in the cycle after the RING_SEC-th `sec_tick` following ring entry.
- A `sec_tick` coincident with ring entry is not counted.
- Re-ring after snooze: `alert` rises the cycle after the SNOOZE_MIN-th `min_evt`.
- Chime rises the cycle after the 00-minute event and falls the cycle after the CHIME_SEC-th `sec_tick`.
- Reset mid-ring/snooze: outputs take reset values in the next cycle; a pending snooze is lost.

## Structure
- Package `alarm_pkg`:
  - `alarm_state_t` enum (IDLE, RINGING, SNOOZE).
  - `BCD_W` = 8.
  - `BCD_ZERO` = 8'h00.
- One sub-module, `tick_counter`:
  - Parameterised width/terminal count with clear/enable/done.
  - Instantiated for `sec_cnt`, `min_cnt` and `chime_cnt`.
- The FSM, minute-edge register and alarm registers live in `alarm_sequencer`.

## Test plan
- Set 07:30, arm=1; step minute 29→30 at hour 07 → `alert`=1 next cycle; 60 `sec_tick`s → `alert`=0, state IDLE.
- Ring, then `stop` at tick 10 → `alert`=0 next cycle; hold minute=30 for 50 more ticks → no retrigger.
- Ring; snooze ×3, each followed by 5 minute events → re-ring each time, `snooze_left` 2,1,0; fourth snooze → IDLE.
- Minute 59→00 while IDLE → `chime`=1 for exactly 2 ticks. Alarm set to hh:00 → `alert`=1 and `chime` stays 0.
- arm=0 during RINGING → IDLE next cycle. Match minute with arm=0 → no ring.
- Reset asserted during SNOOZE with minute changing across the reset → all outputs at reset values, no `min_evt` after release. Also `set_en` during RINGING → registers updated, `alert` unchanged.
